// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared definitions for the register-file sequencer.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-address widths
//   op_e                    : instruction opcode encoding (3 bits)
//   state_e                 : sequencer state encoding
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/regseq_alu.sv
// regseq_alu: combinational ALU for the register-file sequencer.
//   op    in  opcode
//   a, b  in  operands read from the register file
//   imm   in  immediate (LDI)
//   res   out result modulo 2**DATA_W
//   carry out carry-out (ADD) / borrow (SUB), 0 otherwise;
//             port exists only when REGSEQ_FLAGS_EN is defined
module regseq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] res
`ifdef REGSEQ_FLAGS_EN
    ,
    output logic              carry
`endif
);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOV:  res = a;
            OP_LDI:  res = imm;
            default: res = '0;
        endcase
    end

`ifdef REGSEQ_FLAGS_EN
    // a+b overflows exactly when a exceeds the headroom left by b (~b).
    always_comb begin
        carry = 1'b0;
        case (op)
            OP_ADD:  carry = (a > ~b);
            OP_SUB:  carry = (a < b);
            default: carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/regfile_seq.sv
// regfile_seq: multi-cycle sequencer driving a single-port-style register file.
// Each instruction runs as READ -> EXEC -> WRITE (ALU/MOV), WRITE only (LDI),
// or retires at once (NOP). done pulses in the IDLE cycle after retirement.
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       instruction handshake (ready only in IDLE)
//   in_op/rd/rs1/rs2/imm    instruction fields
//   rf_rA/rf_rB/rf_data/rf_we  register-file control (registered)
//   rf_outA/rf_outB         register-file read data
//   done, result            retire pulse and last written value
//   flag_z, flag_c          zero / carry flags, live only with REGSEQ_FLAGS_EN
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] rf_rA,
    output logic [ADDR_W-1:0] rf_rB,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_outA,
    input  logic [DATA_W-1:0] rf_outB,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] alu_res;
    op_e               in_op_e;

    assign in_op_e  = op_e'(in_op);
    assign in_ready = (state == ST_IDLE);

`ifdef REGSEQ_FLAGS_EN
    logic alu_c;
`endif

    regseq_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op_q),
        .a     (rf_outA),
        .b     (rf_outB),
        .imm   (imm_q),
        .res   (alu_res)
`ifdef REGSEQ_FLAGS_EN
        ,
        .carry (alu_c)
`endif
    );

    // Outputs are registered on the edge that enters each state, so the
    // register-file controls are stable for the whole state cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_ADD;
            rd_q    <= '0;
            imm_q   <= '0;
            rf_rA   <= '0;
            rf_rB   <= '0;
            rf_data <= '0;
            rf_we   <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= in_op_e;
                        rd_q  <= in_rd;
                        imm_q <= in_imm;
                        case (in_op_e)
                            OP_LDI: begin
                                rf_rA   <= in_rd;
                                rf_data <= in_imm;
                                rf_we   <= 1'b1;
                                state   <= ST_WRITE;
                            end
                            OP_NOP: begin
                                done <= 1'b1;
                            end
                            default: begin
                                rf_rA <= in_rs1;
                                rf_rB <= in_rs2;
                                state <= ST_READ;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // rf_data doubles as the latched ALU result for WRITE.
                    rf_rA   <= rd_q;
                    rf_data <= alu_res;
                    rf_we   <= 1'b1;
                    state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    rf_we  <= 1'b0;
                    result <= rf_data;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    rf_we <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REGSEQ_FLAGS_EN
    // MOV and LDI touch only the zero flag; the carry flag keeps its value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == ST_EXEC) begin
            flag_z <= (alu_res == '0);
            if (op_q != OP_MOV) begin
                flag_c <= alu_c;
            end
        end else if (state == ST_IDLE && in_valid && in_op_e == OP_LDI) begin
            flag_z <= (in_imm == '0);
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: directed self-checking bench for regfile_seq with a
// behavioural 32x8 register file attached to the rf_* interface.
module tb_regfile_seq;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

`ifdef REGSEQ_FLAGS_EN
    localparam logic FL_EN = 1'b1;
`else
    localparam logic FL_EN = 1'b0;
`endif

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd4,
                           MOV = 3'd5, LDI = 3'd6, NOP = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] rf_rA, rf_rB;
    logic [DATA_W-1:0] rf_data;
    logic              rf_we;
    logic [DATA_W-1:0] rf_outA, rf_outB;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              flag_z, flag_c;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [32];

    always #5 clk = ~clk;

    // Register file: write when we=1, otherwise capture both reads.
    always @(posedge clk) begin
        if (rf_we) mem[rf_rA] <= rf_data;
        else begin
            rf_outA <= mem[rf_rA];
            rf_outB <= mem[rf_rB];
        end
    end

    regfile_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .rf_rA(rf_rA), .rf_rB(rf_rB), .rf_data(rf_data),
        .rf_we(rf_we), .rf_outA(rf_outA), .rf_outB(rf_outB), .done(done),
        .result(result), .flag_z(flag_z), .flag_c(flag_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for ready, then take the accept
    // edge. Returns at 1 ns after the accept edge with in_valid dropped.
    task automatic issue(input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [7:0] imm);
        int n = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 16) begin step(); n++; end
        checks++;
        if (n >= 16) begin
            errors++;
            $display("FAIL issue_ready_timeout in_ready=%b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Issue and wait for done; lat counts cycles from accept to done.
    task automatic run(input logic [2:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [7:0] imm, output int lat);
        issue(op, rd, rs1, rs2, imm);
        lat = 1;
        while (done !== 1'b1 && lat < 16) begin step(); lat++; end
        checks++;
        if (lat >= 16) begin
            errors++;
            $display("FAIL done_timeout done=%b expected 1", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        in_op = NOP; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        step(); step();
        checks++;
        if ({rf_rA, rf_rB, rf_data, rf_we, done, result, flag_z, flag_c} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rA=%h rB=%h data=%h we=%b done=%b result=%h z=%b c=%b expected all 0",
                     rf_rA, rf_rB, rf_data, rf_we, done, result, flag_z, flag_c);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b expected 1", in_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_ldi();
        issue(LDI, 5'd3, 5'd0, 5'd0, 8'h5A);
        checks++;
        if ({rf_we, rf_rA, rf_data, in_ready, done} !== {1'b1, 5'd3, 8'h5A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ldi_write we=%b rA=%0d data=%h ready=%b done=%b expected 1 3 5a 0 0",
                     rf_we, rf_rA, rf_data, in_ready, done);
        end
        step();
        checks++;
        if ({done, result, rf_we, in_ready} !== {1'b1, 8'h5A, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ldi_done done=%b result=%h we=%b ready=%b expected 1 5a 0 1",
                     done, result, rf_we, in_ready);
        end
        checks++;
        if (flag_z !== 1'b0 || mem[3] !== 8'h5A) begin
            errors++;
            $display("FAIL ldi_state z=%b mem3=%h expected 0 5a", flag_z, mem[3]);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL ldi_done_pulse got %b expected 0", done);
        end
    endtask

    task automatic test_add_carry();
        int lat;
        run(LDI, 5'd1, 5'd0, 5'd0, 8'hF0, lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL ldi_latency got %0d expected 2", lat); end
        run(LDI, 5'd2, 5'd0, 5'd0, 8'h20, lat);
        issue(ADD, 5'd4, 5'd1, 5'd2, 8'h00);
        checks++;
        if ({rf_rA, rf_rB, rf_we, in_ready} !== {5'd1, 5'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_read rA=%0d rB=%0d we=%b ready=%b expected 1 2 0 0",
                     rf_rA, rf_rB, rf_we, in_ready);
        end
        step();
        checks++;
        if (rf_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL add_exec we=%b ready=%b expected 0 0", rf_we, in_ready);
        end
        step();
        checks++;
        if ({rf_we, rf_rA, rf_data} !== {1'b1, 5'd4, 8'h10}) begin
            errors++;
            $display("FAIL add_write we=%b rA=%0d data=%h expected 1 4 10", rf_we, rf_rA, rf_data);
        end
        checks++;
        if (flag_c !== FL_EN || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL add_flags c=%b z=%b expected %b 0", flag_c, flag_z, FL_EN);
        end
        step();
        checks++;
        if ({done, result} !== {1'b1, 8'h10} || mem[4] !== 8'h10) begin
            errors++;
            $display("FAIL add_done done=%b result=%h mem4=%h expected 1 10 10", done, result, mem[4]);
        end
    endtask

    task automatic test_sub_xor();
        int lat;
        run(SUB, 5'd5, 5'd2, 5'd2, 8'h00, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL sub_latency got %0d expected 4", lat); end
        checks++;
        if (result !== 8'h00 || mem[5] !== 8'h00) begin
            errors++; $display("FAIL sub_result result=%h mem5=%h expected 00 00", result, mem[5]);
        end
        checks++;
        if (flag_z !== FL_EN || flag_c !== 1'b0) begin
            errors++; $display("FAIL sub_flags z=%b c=%b expected %b 0", flag_z, flag_c, FL_EN);
        end
        run(XOR, 5'd2, 5'd2, 5'd1, 8'h00, lat);
        checks++;
        if (result !== 8'hD0 || mem[2] !== 8'hD0) begin
            errors++; $display("FAIL xor_overlap result=%h mem2=%h expected d0 d0", result, mem[2]);
        end
        checks++;
        if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
            errors++; $display("FAIL xor_flags z=%b c=%b expected 0 0", flag_z, flag_c);
        end
    endtask

    task automatic test_back_to_back();
        issue(MOV, 5'd6, 5'd1, 5'd9, 8'h00);
        // The producer immediately presents a NOP and holds it.
        in_op = NOP; in_rd = 5'd6; in_imm = 8'hEE; in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_busy_ready cycle=%0d got %b expected 0", c, in_ready);
            end
            if (c < 3) step();
        end
        checks++;
        if ({rf_we, rf_rA, rf_data} !== {1'b1, 5'd6, 8'hF0}) begin
            errors++;
            $display("FAIL mov_write we=%b rA=%0d data=%h expected 1 6 f0", rf_we, rf_rA, rf_data);
        end
        step();
        checks++;
        if ({done, in_ready, result} !== {1'b1, 1'b1, 8'hF0}) begin
            errors++;
            $display("FAIL mov_done done=%b ready=%b result=%h expected 1 1 f0", done, in_ready, result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({done, rf_we, in_ready, result} !== {1'b1, 1'b0, 1'b1, 8'hF0}) begin
            errors++;
            $display("FAIL nop_done done=%b we=%b ready=%b result=%h expected 1 0 1 f0",
                     done, rf_we, in_ready, result);
        end
        step();
        checks++;
        if (done !== 1'b0 || rf_we !== 1'b0 || mem[6] !== 8'hF0) begin
            errors++;
            $display("FAIL nop_after done=%b we=%b mem6=%h expected 0 0 f0", done, rf_we, mem[6]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int we_seen = 0;
        run(LDI, 5'd7, 5'd0, 5'd0, 8'h33, lat);
        issue(ADD, 5'd7, 5'd1, 5'd2, 8'h00);
        step();                         // now in EXEC
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rf_rA, rf_rB, rf_data, rf_we, done, result, flag_z, flag_c} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs rA=%h rB=%h data=%h we=%b done=%b result=%h z=%b c=%b expected all 0",
                     rf_rA, rf_rB, rf_data, rf_we, done, result, flag_z, flag_c);
        end
        step();
        if (rf_we !== 1'b0) we_seen++;
        #3 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (rf_we !== 1'b0) we_seen++;
        end
        checks++;
        if (we_seen != 0 || mem[7] !== 8'h33) begin
            errors++;
            $display("FAIL midreset_no_write we_cycles=%0d mem7=%h expected 0 33", we_seen, mem[7]);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_ready got %b expected 1", in_ready);
        end
        run(LDI, 5'd8, 5'd0, 5'd0, 8'h77, lat);
        checks++;
        if (lat != 2 || result !== 8'h77 || mem[8] !== 8'h77) begin
            errors++;
            $display("FAIL ldi_after_reset lat=%0d result=%h mem8=%h expected 2 77 77", lat, result, mem[8]);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub_xor();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout time=%0t expected finish before 100000", $time);
        $fatal(1);
    end

endmodule
